// File: rtl/alu_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_driver_if
//  Description : Request/response valid-ready bundle for alu_driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_driver_if #(
    parameter int TAGW = 4
) ();
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [TAGW-1:0] req_tag;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_result;
    logic            rsp_zero;
    logic            rsp_overflow;
    logic [TAGW-1:0] rsp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_tag
    );
endinterface
`default_nettype wire

// File: rtl/alu_driver.sv
`default_nettype none
// ============================================================================
//  Module      : alu_driver
//  Description : Queues ALU requests, drives a combinational ALU from
//                registers, captures after a settle time and returns a tagged
//                response. Define ALU_DRIVER_CHECK_EN to add the result checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_driver #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2,
    parameter int TAGW   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_driver_if.slave     bus,
    output logic [3:0]      alu_command,
    output logic [31:0]     alu_operandA,
    output logic [31:0]     alu_operandB,
    input  logic [31:0]     alu_result,
    input  logic            alu_carryout,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    output logic            busy
`ifdef ALU_DRIVER_CHECK_EN
    ,
    output logic            check_err,
    output logic [TAGW-1:0] err_tag
`endif
);

    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_CNTW = c_AW + 1;
    localparam int c_CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_AW:0] c_FULL = c_CNTW'(DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_CAPT = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    logic [2:0]      r_fifo_op  [DEPTH];
    logic [31:0]     r_fifo_a   [DEPTH];
    logic [31:0]     r_fifo_b   [DEPTH];
    logic [TAGW-1:0] r_fifo_tag [DEPTH];

    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [1:0]      r_state;
    logic [c_CW-1:0] r_settle;
    logic [TAGW-1:0] r_tag;

    logic [3:0]      r_alu_command;
    logic [31:0]     r_alu_a;
    logic [31:0]     r_alu_b;

    logic            r_rsp_valid;
    logic [31:0]     r_rsp_result;
    logic            r_rsp_zero;
    logic            r_rsp_overflow;
    logic [TAGW-1:0] r_rsp_tag;

    logic            w_push;
    logic            w_pop;
    logic            w_unused_carry;

    assign w_push         = bus.req_valid && bus.req_ready;
    assign w_pop          = (r_state == c_IDLE) && (r_count != '0);
    assign w_unused_carry = alu_carryout;

    assign bus.req_ready    = (r_count != c_FULL);
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_zero     = r_rsp_zero;
    assign bus.rsp_overflow = r_rsp_overflow;
    assign bus.rsp_tag      = r_rsp_tag;

    assign alu_command  = r_alu_command;
    assign alu_operandA = r_alu_a;
    assign alu_operandB = r_alu_b;
    assign busy         = (r_state != c_IDLE) || (r_count != '0);

    // Payload storage carries no reset; validity is governed by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]  <= bus.req_op;
            r_fifo_a[r_wr_ptr]   <= bus.req_a;
            r_fifo_b[r_wr_ptr]   <= bus.req_b;
            r_fifo_tag[r_wr_ptr] <= bus.req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_state        <= c_IDLE;
            r_settle       <= '0;
            r_tag          <= '0;
            r_alu_command  <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_tag      <= '0;
        end else begin
            r_count <= r_count + c_CNTW'(w_push) - c_CNTW'(w_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end

            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_alu_command <= {1'b0, r_fifo_op[r_rd_ptr]};
                        r_alu_a       <= r_fifo_a[r_rd_ptr];
                        r_alu_b       <= r_fifo_b[r_rd_ptr];
                        r_tag         <= r_fifo_tag[r_rd_ptr];
                        r_rd_ptr      <= r_rd_ptr + c_AW'(1);
                        r_settle      <= c_CW'(SETTLE - 1);
                        r_state       <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_settle == '0) begin
                        r_state <= c_CAPT;
                    end else begin
                        r_settle <= r_settle - c_CW'(1);
                    end
                end
                c_CAPT: begin
                    r_rsp_result <= alu_result;
                    r_rsp_zero   <= alu_zero;
                    // Overflow is only meaningful for the arithmetic ops.
                    r_rsp_overflow <= (r_alu_command[2:1] == 2'b00) ? alu_overflow : 1'b0;
                    r_rsp_tag      <= r_tag;
                    r_rsp_valid    <= 1'b1;
                    r_state        <= c_RESP;
                end
                c_RESP: begin
                    if (r_rsp_valid && bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef ALU_DRIVER_CHECK_EN
    logic [31:0]     w_ref_result;
    logic            w_ref_zero;
    logic            w_mismatch;
    logic            r_check_err;
    logic [TAGW-1:0] r_err_tag;

    always_comb begin
        w_ref_result = '0;
        case (r_alu_command[2:0])
            3'd0: w_ref_result = r_alu_a + r_alu_b;
            3'd1: w_ref_result = r_alu_a - r_alu_b;
            3'd2: w_ref_result = r_alu_a ^ r_alu_b;
            3'd3: w_ref_result = {31'd0, ($signed(r_alu_a) < $signed(r_alu_b))};
            3'd4: w_ref_result = r_alu_a & r_alu_b;
            3'd5: w_ref_result = ~(r_alu_a & r_alu_b);
            3'd6: w_ref_result = ~(r_alu_a | r_alu_b);
            3'd7: w_ref_result = r_alu_a | r_alu_b;
            default: w_ref_result = '0;
        endcase
    end

    assign w_ref_zero = (w_ref_result == '0);
    assign w_mismatch = (w_ref_result != alu_result) || (w_ref_zero != alu_zero);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_check_err <= 1'b0;
            r_err_tag   <= '0;
        end else if ((r_state == c_CAPT) && w_mismatch) begin
            r_check_err <= 1'b1;
            if (!r_check_err) begin
                r_err_tag <= r_tag;
            end
        end
    end

    assign check_err = r_check_err;
    assign err_tag   = r_err_tag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_driver
//  Description : Directed vector bench for alu_driver with a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_driver;

    localparam int SETTLE = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_command;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_zero;
    logic        alu_overflow;
    logic        busy;
    logic        inject;
`ifdef ALU_DRIVER_CHECK_EN
    logic        check_err;
    logic [3:0]  err_tag;
`endif

    alu_driver_if #(.TAGW(4)) bus ();

    alu_driver #(.DEPTH(4), .SETTLE(SETTLE), .TAGW(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_command  (alu_command),
        .alu_operandA (alu_operandA),
        .alu_operandB (alu_operandB),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .busy         (busy)
`ifdef ALU_DRIVER_CHECK_EN
        ,
        .check_err    (check_err),
        .err_tag      (err_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; overflow reads 1 for logic ops to mimic a stale flag.
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b1;
        case (alu_command[2:0])
            3'd0: begin
                alu_result   = alu_operandA + alu_operandB;
                alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
            end
            3'd1: begin
                alu_result   = alu_operandA - alu_operandB;
                alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
            end
            3'd2: alu_result = alu_operandA ^ alu_operandB;
            3'd3: alu_result = {31'd0, ($signed(alu_operandA) < $signed(alu_operandB))};
            3'd4: alu_result = alu_operandA & alu_operandB;
            3'd5: alu_result = ~(alu_operandA & alu_operandB);
            3'd6: alu_result = ~(alu_operandA | alu_operandB);
            3'd7: alu_result = alu_operandA | alu_operandB;
            default: alu_result = '0;
        endcase
        alu_result = alu_result ^ {31'd0, inject};
    end
    assign alu_zero     = (alu_result == '0);
    assign alu_carryout = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tg);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tg;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.req_ready) begin
                @(posedge clk); #1;
                bus.req_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: req_ready never seen for tag %0d", tg);
    endtask

    task automatic wait_rsp(output logic [31:0] res, output logic z, output logic ov,
                            output logic [3:0] tg, output logic cmd3, output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_arrived", {31'd0, bus.rsp_valid}, 32'd1);
        res  = bus.rsp_result;
        z    = bus.rsp_zero;
        ov   = bus.rsp_overflow;
        tg   = bus.rsp_tag;
        cmd3 = alu_command[3];
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] r_res;
        logic        r_z;
        logic        r_ov;
        logic [3:0]  r_tg;
        logic        r_c3;
        int          lat;
        int          got;
        int          seen;
        logic        acc;

        vecs[0]  = '{3'd0, 32'd5,          32'd7,          4'd3, 32'd12,         1'b0, 1'b0};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'd1,          4'd4, 32'h7FFF_FFFF,  1'b0, 1'b1};
        vecs[2]  = '{3'd2, 32'hFFFF_0000,  32'hFFFF_0000,  4'd5, 32'd0,          1'b1, 1'b0};
        vecs[3]  = '{3'd0, 32'h7FFF_FFFF,  32'd1,          4'd6, 32'h8000_0000,  1'b0, 1'b1};
        vecs[4]  = '{3'd0, 32'h0000_000F,  32'h0000_00F0,  4'd0, 32'h0000_00FF,  1'b0, 1'b0};
        vecs[5]  = '{3'd1, 32'h0000_000F,  32'h0000_00F0,  4'd1, 32'hFFFF_FF1F,  1'b0, 1'b0};
        vecs[6]  = '{3'd2, 32'h0000_000F,  32'h0000_00F0,  4'd2, 32'h0000_00FF,  1'b0, 1'b0};
        vecs[7]  = '{3'd3, 32'h0000_000F,  32'h0000_00F0,  4'd3, 32'd1,          1'b0, 1'b0};
        vecs[8]  = '{3'd4, 32'h0000_000F,  32'h0000_00F0,  4'd4, 32'd0,          1'b1, 1'b0};
        vecs[9]  = '{3'd5, 32'h0000_000F,  32'h0000_00F0,  4'd5, 32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[10] = '{3'd6, 32'h0000_000F,  32'h0000_00F0,  4'd6, 32'hFFFF_FF00,  1'b0, 1'b0};
        vecs[11] = '{3'd7, 32'h0000_000F,  32'h0000_00F0,  4'd7, 32'h0000_00FF,  1'b0, 1'b0};
        vecs[12] = '{3'd3, 32'hFFFF_FFFF,  32'd1,          4'd8, 32'd1,          1'b0, 1'b0};

        rst_n         = 1'b0;
        inject        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},          32'd0);
        check("rst_cmd",       {28'd0, alu_command},   32'd0);
        check("rst_opA",       alu_operandA,           32'd0);
        check("rst_opB",       alu_operandB,           32'd0);
        check("rst_result",    bus.rsp_result,         32'd0);
        check("rst_tag",       {28'd0, bus.rsp_tag},   32'd0);

        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            check("busy_active", {31'd0, busy}, 32'd1);
            wait_rsp(r_res, r_z, r_ov, r_tg, r_c3, lat);
            check("latency",  lat,           SETTLE + 2);
            check("result",   r_res,         vecs[i].res);
            check("zero",     {31'd0, r_z},  {31'd0, vecs[i].z});
            check("overflow", {31'd0, r_ov}, {31'd0, vecs[i].ov});
            check("tag",      {28'd0, r_tg}, {28'd0, vecs[i].tag});
            check("cmd_bit3", {31'd0, r_c3}, 32'd0);
        end
        check("idle_busy", {31'd0, busy}, 32'd0);

`ifdef ALU_DRIVER_CHECK_EN
        check("chk_clean", {31'd0, check_err}, 32'd0);
        inject = 1'b1;
        send(3'd0, 32'd1, 32'd2, 4'd9);
        wait_rsp(r_res, r_z, r_ov, r_tg, r_c3, lat);
        inject = 1'b0;
        check("chk_err_set", {31'd0, check_err}, 32'd1);
        check("chk_err_tag", {28'd0, err_tag},   32'd9);
        send(3'd0, 32'd4, 32'd4, 4'd10);
        wait_rsp(r_res, r_z, r_ov, r_tg, r_c3, lat);
        check("chk_ok_result", r_res,                32'd8);
        check("chk_sticky",    {31'd0, check_err},   32'd1);
        check("chk_tag_kept",  {28'd0, err_tag},     32'd9);
`endif

        // Backpressure: hold the consumer off until the queue fills.
        for (int t = 0; t < 5; t++) begin
            send(3'd0, 32'(100 + t), 32'(t), 4'(t));
        end
        repeat (10) @(posedge clk);
        #1;
        check("bp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
        check("bp_head",   {28'd0, bus.rsp_tag},   32'd0);
        check("bp_full",   {31'd0, bus.req_ready}, 32'd0);
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd105;
        bus.req_b     = 32'd5;
        bus.req_tag   = 4'd5;
        bus.req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_stalled",     {31'd0, bus.req_ready}, 32'd0);
        check("bp_hold_tag",    {28'd0, bus.rsp_tag},   32'd0);
        check("bp_hold_result", bus.rsp_result,         32'd100);
        check("bp_hold_valid",  {31'd0, bus.rsp_valid}, 32'd1);

        bus.rsp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            acc = bus.req_valid && bus.req_ready;
            if (bus.rsp_valid) begin
                check("bp_order",  {28'd0, bus.rsp_tag}, 32'(got));
                check("bp_result", bus.rsp_result,       32'(100 + 2 * got));
                got++;
            end
            @(posedge clk); #1;
            if (acc) bus.req_valid = 1'b0;
        end
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("bp_count", got, 6);

        // Reset in the middle of an operation with two requests queued.
        send(3'd0, 32'd1, 32'd1, 4'd11);
        send(3'd0, 32'd2, 32'd2, 4'd12);
        send(3'd0, 32'd3, 32'd3, 4'd13);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mr_busy",      {31'd0, busy},          32'd0);
        check("mr_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("mr_cmd",       {28'd0, alu_command},   32'd0);
        check("mr_opA",       alu_operandA,           32'd0);
`ifdef ALU_DRIVER_CHECK_EN
        check("mr_chk_clear", {31'd0, check_err},     32'd0);
`endif
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        bus.rsp_ready = 1'b0;
        check("mr_no_stale", seen, 0);
        check("mr_idle",     {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
